// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
// Holds the parity mode enum, the transmitter FSM state enum, the
// bit-period calculation and the parity helper used by uart_tx_framer.
package uart_pkg;

    // Parity modes, encoded to match the PARITY integer parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Transmitter FSM states, in line order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    // Number of clk cycles per line bit. Clamped to 1 so that a nonsensical
    // CLK_FREQ < BAUD_RATE pairing still elaborates to a usable counter.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        int cpb;
        cpb = clk_freq / baud_rate;
        if (cpb < 1) begin
            cpb = 1;
        end
        return cpb;
    endfunction

    // Parity bit for up to 9 payload bits; unused upper bits must be zero.
    // Even parity is the XOR of the data bits, odd parity its inverse.
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO placed in front of the framer.
// The write side handshake (wr_ready) is a register so the upstream
// ready never depends combinationally on the framer popping a word.
// Read data is show-ahead: rd_data always presents the oldest entry.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           rd_empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    count_reg;
    logic [LW-1:0]    count_next;
    logic             ready_reg;
    logic             push;
    logic             pop;

    // A push is only possible while not full, so push-when-full cannot occur.
    assign push = wr_valid && ready_reg;
    assign pop  = rd_en && (count_reg != '0);

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + LW'(1);
            2'b01:   count_next = count_reg - LW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array; left unreset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            ready_reg <= (count_next != LW'(DEPTH));
        end
    end

    assign wr_ready = ready_reg;
    assign rd_data  = mem[rd_ptr_reg];
    assign rd_empty = (count_reg == '0);
    assign level    = count_reg;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter. Frames each accepted payload as
// start bit, DATA_WIDTH data bits LSB first, optional parity bit and
// STOP_BITS stop bits, each lasting CLK_FREQ/BAUD_RATE clk cycles.
// A new frame may launch in the last cycle of the previous stop bit,
// giving gap-free back-to-back frames.
// Build option: define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry
// uart_tx_fifo in front of the framer (fifo_level then reports its
// occupancy; otherwise fifo_level is constant zero).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int      CPB      = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int      CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int      IDX_W    = $clog2(DATA_WIDTH);
    localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_EVEN :
                                   (PARITY == 2) ? PAR_ODD  : PAR_NONE;
    localparam bit      HAS_PAR  = (PAR_MODE != PAR_NONE);

    tx_state_e             state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  run_reg;

    logic                  bit_done;
    logic                  last_stop;
    logic                  frame_ready;
    logic                  launch_valid;
    logic [DATA_WIDTH-1:0] launch_data;
    logic                  launch;

    // End of the current line bit, and the very last cycle of the frame.
    assign bit_done  = (cnt_reg == CNT_W'(CPB - 1));
    assign last_stop = (state_reg == STOP) && bit_done &&
                       (idx_reg == IDX_W'(STOP_BITS - 1));

    // run_reg holds the framer off for the cycle after reset so that all
    // handshake outputs read as "not ready" while rst is applied.
    assign frame_ready = run_reg && ((state_reg == IDLE) || last_stop);
    assign launch      = frame_ready && launch_valid;

`ifdef UART_TX_FIFO_EN
    logic fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (s_data),
        .wr_valid (s_valid),
        .wr_ready (s_ready),
        .rd_en    (launch),
        .rd_data  (launch_data),
        .rd_empty (fifo_empty),
        .level    (fifo_level)
    );

    assign launch_valid = !fifo_empty;
`else
    // Direct path: the framer itself is the only storage.
    assign s_ready      = frame_ready;
    assign launch_valid = s_valid;
    assign launch_data  = s_data;
    assign fifo_level   = '0;
`endif

    // Frame sequencer: walks START/DATA/PAR/STOP and drives the registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (launch) begin
                // Start bit goes on the line the cycle after the launch.
                state_reg <= START;
                cnt_reg   <= '0;
                idx_reg   <= '0;
                shift_reg <= launch_data;
                par_reg   <= calc_parity(9'(launch_data), PAR_MODE);
                tx_reg    <= 1'b0;
                busy_reg  <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        tx_reg   <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                    START: begin
                        if (bit_done) begin
                            cnt_reg   <= '0;
                            idx_reg   <= '0;
                            state_reg <= DATA;
                            tx_reg    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            cnt_reg <= '0;
                            if (idx_reg == IDX_W'(DATA_WIDTH - 1)) begin
                                idx_reg <= '0;
                                if (HAS_PAR) begin
                                    state_reg <= PAR;
                                    tx_reg    <= par_reg;
                                end else begin
                                    state_reg <= STOP;
                                    tx_reg    <= 1'b1;
                                end
                            end else begin
                                idx_reg   <= idx_reg + IDX_W'(1);
                                tx_reg    <= shift_reg[0];
                                shift_reg <= shift_reg >> 1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        if (bit_done) begin
                            cnt_reg   <= '0;
                            idx_reg   <= '0;
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_done) begin
                            cnt_reg <= '0;
                            if (idx_reg == IDX_W'(STOP_BITS - 1)) begin
                                idx_reg   <= '0;
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                idx_reg <= idx_reg + IDX_W'(1);
                            end
                            tx_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer.
// Four instances (8N1, 8E2, 8O1, 5N1) at CLK_FREQ=400, BAUD_RATE=100
// share clk/rst. Expected line waveforms are computed from the frame
// rules (start, data LSB first, parity from a ones count, stop bits).
// Works with and without UART_TX_FIFO_EN defined.
module tb_uart_tx_framer;

    localparam int NDUT = 4;
    localparam int CPB  = 4;
    localparam int DW_T  [NDUT] = '{8, 8, 8, 5};
    localparam int PAR_T [NDUT] = '{0, 1, 2, 0};
    localparam int SB_T  [NDUT] = '{1, 2, 1, 1};
`ifdef UART_TX_FIFO_EN
    localparam int LAT     = 2;
    localparam bit FIFO_ON = 1'b1;
`else
    localparam int LAT     = 1;
    localparam bit FIFO_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8:0]      s_data [NDUT];
    logic [NDUT-1:0] s_valid;
    logic [NDUT-1:0] s_ready;
    logic [NDUT-1:0] tx;
    logic [NDUT-1:0] busy;
    logic [2:0]      fifo_level [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        uart_tx_framer #(
            .DATA_WIDTH (DW_T[gi]),
            .CLK_FREQ   (400),
            .BAUD_RATE  (100),
            .PARITY     (PAR_T[gi]),
            .STOP_BITS  (SB_T[gi]),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s_data     (s_data[gi][DW_T[gi]-1:0]),
            .s_valid    (s_valid[gi]),
            .s_ready    (s_ready[gi]),
            .tx         (tx[gi]),
            .busy       (busy[gi]),
            .fifo_level (fifo_level[gi])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int frame_len(input int k);
        return 1 + DW_T[k] + ((PAR_T[k] != 0) ? 1 : 0) + SB_T[k];
    endfunction

    // Value of line bit b (0 = start) of a frame carrying d on instance k.
    function automatic logic line_bit(input int k, input logic [8:0] d, input int b);
        int ones;
        ones = 0;
        for (int i = 0; i < DW_T[k]; i++) ones += int'(d[i]);
        if (b == 0) return 1'b0;
        if (b <= DW_T[k]) return d[b-1];
        if (PAR_T[k] != 0 && b == DW_T[k] + 1)
            return (PAR_T[k] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Sampled tx over n cycles with the frame starting at sample 'start'.
    function automatic logic [127:0] tx_wave(input int k, input logic [8:0] d,
                                             input int start, input int n);
        logic [127:0] w;
        int p;
        int len;
        w   = '0;
        len = frame_len(k) * CPB;
        for (int c = 0; c < n; c++) begin
            p    = c - start;
            w[c] = (p >= 0 && p < len) ? line_bit(k, d, p / CPB) : 1'b1;
        end
        return w;
    endfunction

    function automatic logic [127:0] busy_wave(input int k, input int start, input int n);
        logic [127:0] w;
        int p;
        w = '0;
        for (int c = 0; c < n; c++) begin
            p    = c - start;
            w[c] = (p >= 0 && p < frame_len(k) * CPB);
        end
        return w;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic wait_ready(input int k);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!s_ready[k] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready[k]) check($sformatf("ready_wait_dut%0d", k), 128'(s_ready[k]), 128'd1);
    endtask

    task automatic send_frame(input int k, input logic [8:0] d);
        int len;
        int n;
        logic [127:0] tx_got, busy_got, rdy_got, rdy_exp;
        len = frame_len(k) * CPB;
        n   = len + LAT + 1;
        tx_got = '0; busy_got = '0; rdy_got = '0; rdy_exp = '0;
        wait_ready(k);
        s_data[k]  = d;
        s_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tx_got[c]   = tx[k];
            busy_got[c] = busy[k];
            rdy_got[c]  = s_ready[k];
            rdy_exp[c]  = FIFO_ON || (c - (LAT - 1) >= len - 1);
`ifndef UART_TX_FIFO_EN
            // offer junk while not ready; it must not disturb the frame
            s_valid[k] = !s_ready[k] && ($urandom_range(0, 1) == 1);
            s_data[k]  = 9'($urandom);
`endif
        end
        s_valid[k] = 1'b0;
        $display("frame dut%0d data=%03h cycles=%0d tx=%0h", k, d, len, tx_got);
        check($sformatf("tx_dut%0d_%03h", k, d), tx_got, tx_wave(k, d, LAT - 1, n));
        check($sformatf("busy_dut%0d", k), busy_got, busy_wave(k, LAT - 1, n));
        check($sformatf("ready_dut%0d", k), rdy_got, rdy_exp);
    endtask

    task automatic send_pair(input int k, input logic [8:0] d0, input logic [8:0] d1);
        int len;
        int n;
        int nacc;
        bit acc;
        logic [127:0] tx_got, busy_got;
        len = frame_len(k) * CPB;
        n   = 2 * len + LAT + 1;
        tx_got = '0; busy_got = '0;
        wait_ready(k);
        s_data[k]  = d0;
        s_valid[k] = 1'b1;
        nacc = 0;
        for (int c = 0; c < n; c++) begin
            acc = s_valid[k] && s_ready[k];
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) s_data[k] = d1;
                else s_valid[k] = 1'b0;
            end
            @(negedge clk);
            tx_got[c]   = tx[k];
            busy_got[c] = busy[k];
        end
        s_valid[k] = 1'b0;
        $display("pair dut%0d data=%03h,%03h tx=%0h", k, d0, d1, tx_got);
        check($sformatf("pair_tx_dut%0d", k), tx_got,
              tx_wave(k, d0, LAT - 1, n) & tx_wave(k, d1, LAT - 1 + len, n));
        check($sformatf("pair_busy_dut%0d", k), busy_got,
              busy_wave(k, LAT - 1, n) | busy_wave(k, LAT - 1 + len, n));
        check($sformatf("pair_accepts_dut%0d", k), 128'(nacc), 128'd2);
    endtask

    task automatic reset_mid(input int k, input logic [8:0] d0, input logic [8:0] d1);
        int cut;
        logic [127:0] tx_got, busy_got;
        cut = 17 + (LAT - 1);          // second cycle of data bit 3
        tx_got = '0; busy_got = '0;
        wait_ready(k);
        s_data[k]  = d0;
        s_valid[k] = 1'b1;
        @(posedge clk);
        #1;
`ifdef UART_TX_FIFO_EN
        s_data[k] = d1;                // left queued; reset must discard it
        @(posedge clk);
        #1;
`else
        s_data[k] = d1;
`endif
        s_valid[k] = 1'b0;
        for (int c = LAT - 1; c <= cut; c++) @(negedge clk);
        check("pre_reset_bit", 128'(tx[k]), 128'(line_bit(k, d0, (cut - (LAT - 1)) / CPB)));
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort", {tx[k], busy[k], s_ready[k], fifo_level[k]},
              {1'b1, 1'b0, 1'b0, 3'd0});
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 128'(s_ready[k]), 128'd1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            tx_got[c]   = tx[k];
            busy_got[c] = busy[k];
        end
        $display("reset dut%0d data=%03h after-abort tx=%0h", k, d0, tx_got);
        check("post_reset_tx", tx_got, {68'd0, {60{1'b1}}});
        check("post_reset_busy", busy_got, 128'd0);
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic fifo_burst(input int k);
        logic [8:0] q [5];
        logic       tx_s  [256];
        logic       rdy_s [256];
        logic [2:0] lvl_s [256];
        logic [127:0] got;
        int len;
        int n;
        int nacc;
        int rise;
        bit acc;
        for (int i = 0; i < 5; i++) q[i] = 9'($urandom_range(0, 255));
        len = frame_len(k) * CPB;
        n   = 5 * len + LAT + 1;
        wait_ready(k);
        s_data[k]  = q[0];
        s_valid[k] = 1'b1;
        nacc = 0;
        for (int c = 0; c < n; c++) begin
            acc = s_valid[k] && s_ready[k];
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                if (nacc < 5) s_data[k] = q[nacc];
                else s_valid[k] = 1'b0;
            end
            @(negedge clk);
            tx_s[c]  = tx[k];
            rdy_s[c] = s_ready[k];
            lvl_s[c] = fifo_level[k];
        end
        s_valid[k] = 1'b0;
        check("fifo_accepts", 128'(nacc), 128'd5);
        check("fifo_fill_levels", {lvl_s[4], lvl_s[3], lvl_s[2], lvl_s[1], lvl_s[0]},
              {3'd4, 3'd3, 3'd2, 3'd1, 3'd1});
        check("fifo_full_ready", 128'(rdy_s[4]), 128'd0);
        rise = -1;
        for (int c = 5; c < n; c++) if (rdy_s[c] && rise < 0) rise = c;
        check("fifo_ready_rise", 128'(rise), 128'd41);
        check("fifo_level_after_pop", 128'(lvl_s[41]), 128'd3);
        for (int f = 0; f < 5; f++) begin
            got = '0;
            for (int j = 0; j < len; j++) got[j] = tx_s[f * len + LAT - 1 + j];
            $display("fifo frame %0d data=%03h tx=%0h", f, q[f], got);
            check($sformatf("fifo_frame%0d", f), got, tx_wave(k, q[f], 0, len));
        end
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic [8:0] d;
        s_valid = '0;
        for (int i = 0; i < NDUT; i++) s_data[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 128'(tx), 128'hF);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_ready", 128'(s_ready), 128'h0);
        check("reset_level", {fifo_level[3], fifo_level[2], fifo_level[1], fifo_level[0]}, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(s_ready), 128'hF);

        send_frame(0, 9'h0A5);
        send_frame(1, 9'h007);
        send_frame(2, 9'h007);
        send_frame(3, 9'h01F);
        send_pair(0, 9'h055, 9'h0AA);

        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, NDUT - 1);
            d = 9'($urandom_range(0, (1 << DW_T[k]) - 1));
            send_frame(k, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        k = $urandom_range(0, NDUT - 1);
        send_pair(k, 9'($urandom_range(0, (1 << DW_T[k]) - 1)),
                     9'($urandom_range(0, (1 << DW_T[k]) - 1)));

        reset_mid(0, 9'h0B6, 9'h03C);
`ifdef UART_TX_FIFO_EN
        fifo_burst(0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, 8, payload bits per frame, legal 5..9.
REQ-002 Parameter CLK_FREQ, 100_000_000, clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, 115200, line rate in bit/s.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, 4, input FIFO entries, power of two >= 2; used only with UART_TX_FIFO_EN.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 s_data  input  DATA_WIDTH  payload, LSB transmitted first.
REQ-010 s_valid  input  1  payload offered.
REQ-011 s_ready  output  1  block can accept payload this cycle.
REQ-012 tx  output  1  serial line, idles high, registered.
REQ-013 busy  output  1  frame in progress on tx.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy; constant 0 without UART_TX_FIFO_EN.

Function
REQ-015 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division); every line bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-016 Frame SHALL be: start bit 0, DATA_WIDTH data bits LSB first, parity bit if PARITY!=0, STOP_BITS bits of 1.
REQ-017 Even parity SHALL equal XOR of data bits; odd parity SHALL equal its inverse.
REQ-018 FSM states SHALL be IDLE, START, DATA, PAR, STOP; IDLE->START on frame launch, START->DATA, DATA->PAR (or STOP if PARITY=0) after DATA_WIDTH bits, PAR->STOP, STOP->IDLE after STOP_BITS bits unless a new frame launches.
REQ-019 Transfer SHALL occur only on cycle where s_valid && s_ready; s_data is sampled that cycle only.
REQ-020 Without FIFO, s_ready SHALL be high in IDLE and in the final cycle of the last stop bit, low otherwise.
REQ-021 Launch on accept: start bit SHALL appear on tx the cycle after transfer (latency 1).
REQ-022 Back-to-back frames SHALL have zero idle cycles: frame period exactly (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-023 busy SHALL be high from the first start-bit cycle through the last stop-bit cycle, low in IDLE.
REQ-024 s_valid asserted while s_ready low SHALL have no effect.

Reset
REQ-025 During rst: tx=1, busy=0, s_ready=0, fifo_level=0, FSM=IDLE, counters=0; outputs take these values the cycle after rst is sampled high.
REQ-026 rst mid-frame SHALL abort the frame, return tx high next cycle, discard FIFO contents; no partial frame resumes.
REQ-027 s_ready SHALL go high the first cycle after rst deasserts.

Configuration
REQ-028 Macro UART_TX_FIFO_EN defined: FIFO_DEPTH-entry FIFO precedes the framer; s_ready = !full; FSM pops when idle or in final stop cycle; start-bit latency from transfer into empty FIFO SHALL be 2 cycles.
REQ-029 With FIFO, push when full SHALL be impossible (s_ready low); simultaneous push and pop SHALL leave fifo_level unchanged; s_ready SHALL be registered and not depend combinationally on pop.
REQ-030 Macro undefined: no FIFO storage, REQ-020/REQ-021 apply, fifo_level tied 0.

Structure
REQ-031 Package uart_pkg SHALL hold parity enum (PAR_NONE/PAR_EVEN/PAR_ODD), tx FSM state enum, and function computing CLKS_PER_BIT.
REQ-032 FIFO SHALL be sub-module uart_tx_fifo (parameters WIDTH, DEPTH), instantiated only under UART_TX_FIFO_EN.

Verification (CLK_FREQ=400, BAUD_RATE=100 -> CLKS_PER_BIT=4)
REQ-033 8N1, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles; s_ready high again in cycle 40.
REQ-034 8E2, send 0x07 -> parity bit 1, two stop bits, frame 48 cycles; 8O1 send 0x07 -> parity bit 0.
REQ-035 s_valid held with 0x55 then 0xAA -> second start bit immediately after first stop bit, no idle cycle.
REQ-036 rst pulse during data bit 3 -> tx=1 and busy=0 next cycle; no further frame bits emitted.
REQ-037 UART_TX_FIFO_EN, DEPTH=4: push 5 bytes back-to-back -> s_ready low after 4th accept until first pop; all bytes transmitted in order; fifo_level tracks 0..4.
REQ-038 DATA_WIDTH=5, 0x1F -> 5 data bits of 1, frame 28 cycles (5N1).
